debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  - CHANNELS-wide debouncer for front-panel switches and buttons (step, run/halt, reset request, manual bits).
//  - Per channel: synchroniser, then symmetric debounce on both press and release.
//  - Registered level plus one-cycle press/release strobes per channel.
//  - Optional auto-repeat strobe while a button is held.
// PARAMETERS
//  CHANNELS        4        number of independent input channels (>=1)
//  SYNC_STAGES     2        synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES 1000000  consecutive cycles an input must differ from level before level flips (>=2)
//  ACTIVE_LOW      0        1: raw pin low = pressed; inverted after the synchroniser
//  REPEAT_EN       0        1: enable auto-repeat strobes
//  REPEAT_DELAY    25000000 cycles from press strobe to first repeat strobe (>=1)
//  REPEAT_PERIOD   5000000  cycles between subsequent repeat strobes (>=1)
// PORTS
//  clk      in   1         system clock, all logic on rising edge
//  rst      in   1         asynchronous, active-high reset
//  in       in   CHANNELS  raw asynchronous switch inputs
//  level    out  CHANNELS  debounced state, 1 = pressed
//  press    out  CHANNELS  one-cycle pulse on debounced 0->1
//  release  out  CHANNELS  one-cycle pulse on debounced 1->0
//  repeat   out  CHANNELS  one-cycle auto-repeat pulse; tied 0 when REPEAT_EN=0
//  strobe   out  CHANNELS  press | repeat
// BEHAVIOUR
//  - Reset values:
//    - All outputs 0; counters 0; FSM in IDLE.
//    - Sync flops reset to the inactive raw level (1 if ACTIVE_LOW), so no false press on release of rst.
//  - Sync: s = last sync stage (XOR ACTIVE_LOW). Channels are fully independent; no cross-channel coupling.
//  - Debounce counter:
//    - Width $clog2(DEBOUNCE_CYCLES).
//    - While s != level: ctr increments each cycle.
//    - When s == level: ctr cleared to 0. Any glitch restarts the count.
//    - When s != level and ctr == DEBOUNCE_CYCLES-1: next edge level <= s, ctr <= 0, and press or release pulses for exactly that cycle.
//  - Latency: a clean step on in that is held produces press/level high exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge sampling the new value. Release latency is identical (symmetric).
//  - Minimum spacing: consecutive press strobes on one channel are separated by >= 2*DEBOUNCE_CYCLES cycles.
//  - Repeat FSM (per channel, REPEAT_EN=1), rep_ctr width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)):
//    - IDLE: on press -> DELAY, rep_ctr 0.
//    - DELAY: rep_ctr counts. At REPEAT_DELAY-1: repeat pulses, -> RPT, rep_ctr 0.
//    - RPT: at REPEAT_PERIOD-1: repeat pulses, rep_ctr 0, stay in RPT.
//    - Any state: release (debounced) -> IDLE next edge, rep_ctr 0, no repeat that cycle. Release wins over a coincident repeat terminal count.
//  - press and repeat are never high together on a channel; strobe is a simple OR.
//  - rst mid-count or mid-repeat:
//    - Immediate async clear.
//    - After deassertion, a still-held button needs a full SYNC_STAGES+DEBOUNCE_CYCLES before press.
//  - Counters never wrap: terminal compare always resets them before overflow.
// STRUCTURE
//  - Shared header debounce_defs.vh: repeat FSM state encodings (IDLE=2'd0, DELAY=2'd1, RPT=2'd2); 2'd3 decodes to IDLE.
//  - Sub-module debounce_chan: one channel holding sync, counter, level, edge pulses and repeat FSM.
//  - debounce_bank: generate loop of CHANNELS instances plus output concatenation; no other logic.
// TESTING (bench params: CHANNELS=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  1. in[0] 0->1 held -> press[0] single pulse and level[0]=1 exactly 10 cycles later; other channels stay 0.
//  2. in[1] toggles every 3 cycles for 60 cycles -> level[1], press[1], release[1] all stay 0.
//  3. in[2] high, level settles, then in[2]=0 held -> release[2] pulse 10 cycles after drop; no repeat after.
//  4. in[0] held 60 cycles past press -> repeat[0] at press+20, +25, +30 ...; strobe[0] = press|repeat.
//  5. Release coincident with repeat terminal count -> release pulses, repeat does not, FSM IDLE.
//  6. rst pulsed async mid-debounce and mid-RPT with in held -> outputs 0 at once; press again 10 cycles after rst falls.
//  7. ACTIVE_LOW=1, in idle at 1 through reset -> no press; in=0 held -> press after 10 cycles.

Source files
------------

// File: rtl/debounce_bank_pkg.sv
// Shared types for the front-panel debounce bank.
// Repeat FSM encodings and counter-width helpers.
package debounce_bank_pkg;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_DELAY = 2'd1,
        RS_RPT   = 2'd2
    } rep_state_e;

    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_bank_chan.sv
// One debounce channel: synchroniser, symmetric debounce,
// edge pulses and auto-repeat FSM.
module debounce_bank_chan
    import debounce_bank_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic strobe
);

    localparam int   CW       = ctr_width(DEBOUNCE_CYCLES);
    localparam int   RW       = ctr_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          ctr;
    logic                   s;
    logic                   flip;
    logic                   rise;
    logic                   fall;

    rep_state_e             state;
    rep_state_e             state_n;
    logic [RW-1:0]          rep_ctr;
    logic [RW-1:0]          rep_ctr_n;
    logic                   fire;

    // Sync flops idle at the inactive pin level so reset release is quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RAW_IDLE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
        end
    end

    assign s    = sync[SYNC_STAGES-1] ^ RAW_IDLE;
    assign flip = (s != level) && (ctr == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && s;
    assign fall = flip && !s;

    // Debounce counter, registered level and press/release pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= rise;
            release_pulse <= fall;
            if (s == level) begin
                ctr <= '0;
            end else if (flip) begin
                ctr   <= '0;
                level <= s;
            end else begin
                ctr <= ctr + CW'(1);
            end
        end
    end

    // Repeat FSM state, counter and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RS_IDLE;
            rep_ctr      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            rep_ctr      <= rep_ctr_n;
            repeat_pulse <= fire;
        end
    end

    // Repeat next-state; a debounced release overrides any terminal count
    always_comb begin
        state_n   = state;
        rep_ctr_n = rep_ctr;
        fire      = 1'b0;
        case (state)
            RS_IDLE: begin
                if (rise) begin
                    state_n   = RS_DELAY;
                    rep_ctr_n = '0;
                end
            end
            RS_DELAY: begin
                if (rep_ctr == RW'(REPEAT_DELAY - 1)) begin
                    fire      = 1'b1;
                    state_n   = RS_RPT;
                    rep_ctr_n = '0;
                end else begin
                    rep_ctr_n = rep_ctr + RW'(1);
                end
            end
            RS_RPT: begin
                if (rep_ctr == RW'(REPEAT_PERIOD - 1)) begin
                    fire      = 1'b1;
                    rep_ctr_n = '0;
                end else begin
                    rep_ctr_n = rep_ctr + RW'(1);
                end
            end
            default: begin
                state_n   = RS_IDLE;
                rep_ctr_n = '0;
            end
        endcase
        if (fall || (REPEAT_EN == 0)) begin
            state_n   = RS_IDLE;
            rep_ctr_n = '0;
            fire      = 1'b0;
        end
    end

    assign strobe = press | repeat_pulse;

endmodule

// File: rtl/debounce_bank.sv
// CHANNELS-wide debouncer for front-panel switches and buttons.
// Pure wrapper: one independent channel per input bit.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic [CHANNELS-1:0] strobe
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_bank_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .in            (in[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .strobe        (strobe[i])
        );
    end

endmodule
